// File: rtl/sram_async_ctrl.sv
// ---------------------------------------------------------------------------
// sram_async_ctrl
//
// Host-side initiator for a 128K x 8 asynchronous SRAM (AS6C1008-class).
// Takes single-byte read/write requests over a valid/ready handshake and
// sequences CE#/CE2/OE#/WE#, the address and the data bus using
// cycle-counted phases. The tristate DQ buffer lives at the top level and is
// controlled by sram_dq_oe.
//
// Parameters (cycle counts, values below 1 are treated as 1, above 15 as 15):
//   RD_WAIT   OE# low before read data is captured
//   WR_SETUP  address/data/CE# valid with WE# high before the WE# pulse
//   WR_PULSE  WE# low
//   WR_HOLD   WE# high again with address/data still held
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_we              1 = write, 0 = read
//   req_addr/req_wdata  byte address and write data, latched on accept
//   rsp_valid/rsp_data  one-cycle read-data strobe, data held afterwards
//   sram_addr           A16..A0
//   sram_dq_out/_in     data towards / from the DQ pins
//   sram_dq_oe          1 = FPGA drives DQ
//   sram_ce_n/sram_ce2  chip enables (CE2 is always the inverse of CE#)
//   sram_oe_n/sram_we_n output enable and write enable strobes
// ---------------------------------------------------------------------------
module sram_async_ctrl #(
    parameter int RD_WAIT  = 1,
    parameter int WR_SETUP = 1,
    parameter int WR_PULSE = 1,
    parameter int WR_HOLD  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [16:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic [16:0] sram_addr,
    output logic [7:0]  sram_dq_out,
    input  logic [7:0]  sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_ce2,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    // Phase lengths clamped into what the 4-bit counter can represent.
    localparam int RdLen = (RD_WAIT  < 1) ? 1 : ((RD_WAIT  > 15) ? 15 : RD_WAIT);
    localparam int WsLen = (WR_SETUP < 1) ? 1 : ((WR_SETUP > 15) ? 15 : WR_SETUP);
    localparam int WpLen = (WR_PULSE < 1) ? 1 : ((WR_PULSE > 15) ? 15 : WR_PULSE);
    localparam int WhLen = (WR_HOLD  < 1) ? 1 : ((WR_HOLD  > 15) ? 15 : WR_HOLD);

    localparam logic [3:0] RdLoad = 4'(RdLen - 1);
    localparam logic [3:0] WsLoad = 4'(WsLen - 1);
    localparam logic [3:0] WpLoad = 4'(WpLen - 1);
    localparam logic [3:0] WhLoad = 4'(WhLen - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WSETUP,
        WPULSE,
        WHOLD
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] addr_q, addr_d;
    logic [7:0]  dqOut_q, dqOut_d;
    logic [7:0]  rspData_q, rspData_d;
    logic        rspValid_q, rspValid_d;
    logic        reqReady_q, reqReady_d;
    logic        ceN_q, ceN_d;
    logic        ce2_q;
    logic        oeN_q, oeN_d;
    logic        weN_q, weN_d;
    logic        dqOe_q, dqOe_d;

    // Next-state logic. Every phase loads the counter with its length minus
    // one on entry and moves on once the counter has run down to zero. The
    // pin-level outputs are then decoded from the *next* state so that the
    // registered strobes line up with the state they belong to, keeping
    // every output registered without adding a cycle of latency.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        dqOut_d    = dqOut_q;
        rspData_d  = rspData_q;
        rspValid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && reqReady_q) begin
                    addr_d  = req_addr;
                    dqOut_d = req_wdata;
                    if (req_we) begin
                        state_d = WSETUP;
                        cnt_d   = WsLoad;
                    end else begin
                        state_d = RD;
                        cnt_d   = RdLoad;
                    end
                end
            end
            RD: begin
                if (cnt_q == 4'd0) begin
                    state_d    = IDLE;
                    cnt_d      = 4'd0;
                    rspValid_d = 1'b1;
                    rspData_d  = sram_dq_in;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WSETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = WPULSE;
                    cnt_d   = WpLoad;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WPULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = WHOLD;
                    cnt_d   = WhLoad;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WHOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        reqReady_d = (state_d == IDLE);
        ceN_d      = (state_d == IDLE);
        oeN_d      = (state_d != RD);
        weN_d      = (state_d != WPULSE);
        dqOe_d     = (state_d == WSETUP) || (state_d == WPULSE) || (state_d == WHOLD);
    end

    // State and output registers. Reset forces every strobe inactive on the
    // same edge, so an interrupted WE# pulse ends immediately and an
    // in-flight read never raises rsp_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 17'd0;
            dqOut_q    <= 8'd0;
            rspData_q  <= 8'd0;
            rspValid_q <= 1'b0;
            reqReady_q <= 1'b0;
            ceN_q      <= 1'b1;
            ce2_q      <= 1'b0;
            oeN_q      <= 1'b1;
            weN_q      <= 1'b1;
            dqOe_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            dqOut_q    <= dqOut_d;
            rspData_q  <= rspData_d;
            rspValid_q <= rspValid_d;
            reqReady_q <= reqReady_d;
            ceN_q      <= ceN_d;
            ce2_q      <= ~ceN_d;
            oeN_q      <= oeN_d;
            weN_q      <= weN_d;
            dqOe_q     <= dqOe_d;
        end
    end

    assign req_ready   = reqReady_q;
    assign rsp_valid   = rspValid_q;
    assign rsp_data    = rspData_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dqOut_q;
    assign sram_dq_oe  = dqOe_q;
    assign sram_ce_n   = ceN_q;
    assign sram_ce2    = ce2_q;
    assign sram_oe_n   = oeN_q;
    assign sram_we_n   = weN_q;

endmodule

// File: tb/tb_sram_async_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_async_ctrl
//
// Two controller instances share one clock: dut0 with default timing and
// dut1 with RD_WAIT=3, WR_SETUP=2, WR_PULSE=4, WR_HOLD=2. Each has its own
// behavioural asynchronous SRAM. Expected read data comes from a reference
// memory keyed by instance and address; expected pin waveforms come from the
// phase lengths of each instance.
// ---------------------------------------------------------------------------
module tb_sram_async_ctrl;

    localparam int RDW [2] = '{1, 3};
    localparam int WS  [2] = '{1, 2};
    localparam int WP  [2] = '{1, 4};
    localparam int WH  [2] = '{1, 2};

    logic        clk = 1'b0;
    logic        rst_n       [2];
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic        req_we      [2];
    logic [16:0] req_addr    [2];
    logic [7:0]  req_wdata   [2];
    logic        rsp_valid   [2];
    logic [7:0]  rsp_data    [2];
    logic [16:0] sram_addr   [2];
    logic [7:0]  sram_dq_out [2];
    logic [7:0]  sram_dq_in  [2];
    logic        sram_dq_oe  [2];
    logic        sram_ce_n   [2];
    logic        sram_ce2    [2];
    logic        sram_oe_n   [2];
    logic        sram_we_n   [2];

    logic [7:0]  mem0 [0:131071];
    logic [7:0]  mem1 [0:131071];
    logic [7:0]  refMem [int];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    // Behavioural SRAMs: a byte is stored while CE# and WE# are low, and the
    // array drives DQ only while CE# and OE# are low.
    always @(posedge clk) begin
        if (!sram_we_n[0] && !sram_ce_n[0]) mem0[sram_addr[0]] <= sram_dq_out[0];
        if (!sram_we_n[1] && !sram_ce_n[1]) mem1[sram_addr[1]] <= sram_dq_out[1];
    end

    assign sram_dq_in[0] = (!sram_ce_n[0] && !sram_oe_n[0]) ? mem0[sram_addr[0]] : 8'h00;
    assign sram_dq_in[1] = (!sram_ce_n[1] && !sram_oe_n[1]) ? mem1[sram_addr[1]] : 8'h00;

    sram_async_ctrl dut0 (
        .clk(clk), .rst_n(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
        .sram_addr(sram_addr[0]), .sram_dq_out(sram_dq_out[0]), .sram_dq_in(sram_dq_in[0]),
        .sram_dq_oe(sram_dq_oe[0]), .sram_ce_n(sram_ce_n[0]), .sram_ce2(sram_ce2[0]),
        .sram_oe_n(sram_oe_n[0]), .sram_we_n(sram_we_n[0])
    );

    sram_async_ctrl #(.RD_WAIT(3), .WR_SETUP(2), .WR_PULSE(4), .WR_HOLD(2)) dut1 (
        .clk(clk), .rst_n(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
        .sram_addr(sram_addr[1]), .sram_dq_out(sram_dq_out[1]), .sram_dq_in(sram_dq_in[1]),
        .sram_dq_oe(sram_dq_oe[1]), .sram_ce_n(sram_ce_n[1]), .sram_ce2(sram_ce2[1]),
        .sram_oe_n(sram_oe_n[1]), .sram_we_n(sram_we_n[1])
    );

    // Packs every output of one instance in reset-value order.
    function automatic logic [39:0] outVec(input int i);
        return {req_ready[i], rsp_valid[i], rsp_data[i], sram_addr[i], sram_dq_out[i],
                sram_dq_oe[i], sram_ce_n[i], sram_ce2[i], sram_oe_n[i], sram_we_n[i]};
    endfunction

    localparam logic [39:0] ResetVec = {1'b0, 1'b0, 8'h00, 17'h00000, 8'h00,
                                        1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // Issues one request and follows it cycle by cycle until the controller
    // is idle again. Cycle k counts from 1 = first cycle after the accept.
    task automatic run_op(input int i, input bit we, input logic [16:0] addr,
                          input logic [7:0] wd, input bit hold, input string name);
        int T;
        int n;
        int key;
        logic [5:0] expV;
        logic [5:0] actV;
        logic [7:0] expRd;
        key   = i * 131072 + int'(addr);
        T     = we ? (WS[i] + WP[i] + WH[i]) : RDW[i];
        expRd = refMem.exists(key) ? refMem[key] : 8'h00;
        @(negedge clk);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wd;
        n = 0;
        while (req_ready[i] !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 64) begin
            $display("[TB] FAIL %s dut%0d accept: req_ready stayed %b, required 1", name, i, req_ready[i]);
            req_valid[i] = 1'b0;
            return;
        end else passes++;
        @(posedge clk);
        #1;
        if (!hold) req_valid[i] = 1'b0;
        if (we) refMem[key] = wd;
        for (int k = 1; k <= T + 1; k++) begin
            expV = {k == T + 1, k == T + 1,
                    we ? 1'b1 : (k > T),
                    we ? !(k > WS[i] && k <= WS[i] + WP[i]) : 1'b1,
                    we && (k <= T),
                    !we && (k == T + 1)};
            actV = {req_ready[i], sram_ce_n[i], sram_oe_n[i], sram_we_n[i], sram_dq_oe[i], rsp_valid[i]};
            checks++;
            if (actV !== expV)
                $display("[TB] FAIL %s dut%0d cycle %0d {ready,ce_n,oe_n,we_n,dq_oe,rsp_valid}: got %b, required %b",
                         name, i, k, actV, expV);
            else passes++;
            checks++;
            if ((!sram_oe_n[i] && sram_dq_oe[i]) || (!sram_oe_n[i] && !sram_we_n[i]) ||
                (sram_ce2[i] !== ~sram_ce_n[i]))
                $display("[TB] FAIL %s dut%0d cycle %0d invariant: oe_n=%b we_n=%b dq_oe=%b ce_n=%b ce2=%b",
                         name, i, k, sram_oe_n[i], sram_we_n[i], sram_dq_oe[i], sram_ce_n[i], sram_ce2[i]);
            else passes++;
            checks++;
            if (sram_addr[i] !== addr || (we && k <= T && sram_dq_out[i] !== wd))
                $display("[TB] FAIL %s dut%0d cycle %0d addr/data: got %h/%h, required %h/%h",
                         name, i, k, sram_addr[i], sram_dq_out[i], addr, wd);
            else passes++;
            if (k <= T) begin
                @(posedge clk);
                #1;
            end
        end
        if (!we) begin
            checks++;
            if (rsp_data[i] !== expRd)
                $display("[TB] FAIL %s dut%0d rsp_data: got %h, required %h", name, i, rsp_data[i], expRd);
            else passes++;
        end
    endtask

    // Reset held for three cycles with a request pending on both instances.
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            rst_n[i]     = 1'b0;
            req_valid[i] = 1'b1;
            req_we[i]    = 1'b1;
            req_addr[i]  = 17'h1ABCD;
            req_wdata[i] = 8'h5A;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (outVec(i) !== ResetVec)
                    $display("[TB] FAIL reset_values dut%0d: got %h, required %h", i, outVec(i), ResetVec);
                else passes++;
            end
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            rst_n[i]     = 1'b1;
            req_valid[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (req_ready[i] !== 1'b1)
                $display("[TB] FAIL ready_after_reset dut%0d: got %b, required 1", i, req_ready[i]);
            else passes++;
        end
    endtask

    task automatic test_write_read_default();
        run_op(0, 1'b1, 17'h12345, 8'hA5, 1'b0, "wr_default");
        run_op(0, 1'b0, 17'h12345, 8'h00, 1'b0, "rd_default");
    endtask

    // req_valid stays high across a write/read/write chain.
    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            run_op(i, 1'b1, 17'h1FFFF, 8'h3C, 1'b1, "b2b_wr_top");
            run_op(i, 1'b0, 17'h1FFFF, 8'h00, 1'b1, "b2b_rd_top");
            run_op(i, 1'b1, 17'h00000, 8'hFF, 1'b0, "b2b_wr_zero");
        end
    endtask

    task automatic test_slow_timing();
        logic [7:0] d;
        d = 8'($urandom);
        run_op(1, 1'b1, 17'h0ABCD, d, 1'b0, "slow_wr");
        run_op(1, 1'b0, 17'h0ABCD, 8'h00, 1'b0, "slow_rd");
    endtask

    // Reset lands while WE# is low; strobes must drop on that edge and the
    // interrupted write must not leave a response behind.
    task automatic test_reset_mid_write(input int i, input logic [16:0] knownAddr);
        logic [16:0] a;
        int n;
        a = 17'h08000 | 17'($urandom_range(0, 4095));
        @(negedge clk);
        req_valid[i] = 1'b1;
        req_we[i]    = 1'b1;
        req_addr[i]  = a;
        req_wdata[i] = 8'($urandom);
        n = 0;
        while (req_ready[i] !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        repeat (WS[i]) @(posedge clk);
        #1;
        checks++;
        if (sram_we_n[i] !== 1'b0)
            $display("[TB] FAIL midrst_in_pulse dut%0d we_n: got %b, required 0", i, sram_we_n[i]);
        else passes++;
        @(negedge clk);
        rst_n[i] = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (outVec(i) !== ResetVec)
            $display("[TB] FAIL midrst_values dut%0d: got %h, required %h", i, outVec(i), ResetVec);
        else passes++;
        refMem.delete(i * 131072 + int'(a));
        @(negedge clk);
        rst_n[i] = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            checks++;
            if (rsp_valid[i] !== 1'b0 || sram_we_n[i] !== 1'b1)
                $display("[TB] FAIL midrst_quiet dut%0d rsp_valid/we_n: got %b/%b, required 0/1",
                         i, rsp_valid[i], sram_we_n[i]);
            else passes++;
        end
        run_op(i, 1'b0, knownAddr, 8'h00, 1'b0, "midrst_read");
    endtask

    // Random mix over a small address pool; reads only target addresses
    // whose content the reference memory knows.
    task automatic test_random();
        logic [16:0] pool [6];
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 5; p++) pool[p] = 17'h18000 | 17'($urandom_range(0, 32767));
            pool[5] = 17'h1FFFF;
            for (int n = 0; n < 24; n++) begin
                logic [16:0] a;
                bit w;
                a = pool[$urandom_range(0, 5)];
                w = !refMem.exists(i * 131072 + int'(a)) || ($urandom_range(0, 1) == 1);
                run_op(i, w, a, 8'($urandom), bit'($urandom_range(0, 1)), w ? "rand_wr" : "rand_rd");
            end
            req_valid[i] = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i]     = 1'b0;
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = 17'h0;
            req_wdata[i] = 8'h0;
        end
        test_reset();
        test_write_read_default();
        test_back_to_back();
        test_slow_timing();
        test_reset_mid_write(0, 17'h12345);
        test_reset_mid_write(1, 17'h0ABCD);
        test_random();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sram_async_ctrl.md
Name: sram_async_ctrl

Overview:
Host-side initiator for the external 128K x 8 asynchronous SRAM (AS6C1008-class) on the FPGA board. Accepts single-byte read/write requests over a valid/ready handshake and sequences CE#/CE2/OE#/WE#, the 17-bit address and the bidirectional data bus with cycle-counted timing. Sits between user logic and the top-level SRAM pins; the tristate buffer lives at top level, driven by sram_dq_oe.

Parameters:
RD_WAIT, 1, cycles OE# low before capturing read data (covers tAA/tOE); legal range 1..15, values below 1 treated as 1
WR_SETUP, 1, cycles address/data/CE# valid with WE# high before the WE# pulse (tAS); legal range 1..15, values below 1 treated as 1
WR_PULSE, 1, cycles WE# low (tWP, tDW); legal range 1..15, values below 1 treated as 1
WR_HOLD, 1, cycles WE# high with address/data still held (tWR, tDH); legal range 1..15, values below 1 treated as 1

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
req_valid  in  1  request present
req_ready  out  1  controller can accept; high only in IDLE
req_we  in  1  1 = write, 0 = read
req_addr  in  17  byte address
req_wdata  in  8  write data
rsp_valid  out  1  one-cycle pulse, read data valid
rsp_data  out  8  read data; holds last value
sram_addr  out  17  to A16..A0 (bit n drives An)
sram_dq_out  out  8  data to pins (bit n drives DQn)
sram_dq_in  in  8  data from pins
sram_dq_oe  out  1  1 = FPGA drives DQ
sram_ce_n  out  1  CE#
sram_ce2  out  1  CE2, always equal to ~sram_ce_n
sram_oe_n  out  1  OE#
sram_we_n  out  1  WE#

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n). Every output is registered.
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_ce_n=1, sram_ce2=0, sram_oe_n=1, sram_we_n=1, state=IDLE, counter=0. req_ready is 1 in the first cycle after rst_n goes high.
- Handshake: a request is accepted at an edge where req_valid & req_ready. On that edge, req_addr and req_wdata are latched into sram_addr and sram_dq_out, and req_ready drops. Requests are never queued.
- IDLE: ce_n=1, oe_n=1, we_n=1, dq_oe=0, req_ready=1. IDLE always lasts at least 1 cycle between operations, which provides bus turnaround.
- Read: RD state lasts RD_WAIT cycles with ce_n=0, oe_n=0, dq_oe=0. On the last RD edge, sram_dq_in is captured into rsp_data, rsp_valid is set, and the FSM returns to IDLE (ce_n=1, oe_n=1). For an accept at edge E0, rsp_valid is high in cycle RD_WAIT+1 for exactly 1 cycle, concurrent with req_ready=1. There is no response backpressure.
- Write: WSETUP (WR_SETUP cycles: ce_n=0, dq_oe=1, we_n=1) -> WPULSE (WR_PULSE cycles: we_n=0) -> WHOLD (WR_HOLD cycles: we_n=1, dq_oe=1, ce_n=0) -> IDLE. sram_addr and sram_dq_out are stable for the whole write. A write produces no response. Occupancy is WR_SETUP+WR_PULSE+WR_HOLD cycles, plus 1 IDLE cycle.
- Invariants:
  - oe_n=0 and dq_oe=1 never occur in the same cycle.
  - oe_n=1 during any write state.
  - we_n=0 only in WPULSE.
  - we_n and oe_n are never both 0.
- A single 4-bit down-counter is loaded with the phase length minus 1 on each state entry; the state advances when the counter reaches 0.
- sram_addr retains its last value in IDLE. Address 0x1FFFF is valid; there is no wrap or increment.
- Reset mid-operation: on the edge where rst_n=0, all outputs take reset values. WE# deasserts on that same edge, any in-flight read produces no rsp_valid, and the write outcome is undefined.
- req_valid high during reset is ignored.

Test Plan:
- rst_n low 3 cycles with req_valid=1 -> all outputs at reset values, no strobe toggles; req_ready=1 in the first cycle after release.
- Write addr 0x12345, data 0xA5 (defaults) -> ce_n low 3 cycles; we_n low exactly in cycle 2 after accept; sram_addr=0x12345 and dq_out=0xA5 with dq_oe=1 throughout; oe_n=1 throughout; req_ready returns after 3 cycles.
- Read 0x12345 against the behavioural SRAM model holding 0xA5 -> oe_n low 1 cycle; rsp_valid pulses in cycle 2 after accept with rsp_data=0xA5.
- req_valid held high: write 0x1FFFF/0x3C, then read 0x1FFFF, then write 0x00000/0xFF -> ≥1 cycle with dq_oe=0 and oe_n=1 at each turnaround; read returns 0x3C; invariants hold every cycle.
- RD_WAIT=3, WR_SETUP=2, WR_PULSE=4, WR_HOLD=2 -> oe_n low 3 cycles with rsp_valid in cycle 4; we_n low exactly 4 cycles starting in cycle 3; write occupancy 8 cycles.
- rst_n asserted during WPULSE -> we_n=1 and dq_oe=0 on that edge; no rsp_valid; a subsequent read completes normally.
